// File: rtl/bus_pkg.sv
// Shared types and constants for the bus target: FSM states, completion codes,
// register offsets and counter widths.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    READY,
    DONE
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RO      = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PARAM  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned TMO_CNT_W  = 8;

  // CTRL and PARAM are the only writable registers
  function automatic logic is_rw_reg(input logic [1:0] off);
    return (off == REG_CTRL) || (off == REG_PARAM);
  endfunction

endpackage

// File: rtl/bus_target_regfile.sv
// CTRL/PARAM storage and the four-entry read mux of the bus target.
module bus_target_regfile
  import bus_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0]   DEVICE_ID  = DATA_WIDTH'(16'hC3D1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_c,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] rdata_c,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  output logic [DATA_WIDTH-1:0] param_out
);

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] param_q, param_d;

  always_comb begin
    ctrl_d  = ctrl_q;
    param_d = param_q;
    if (we_c) begin
      if (offset == REG_CTRL)  ctrl_d  = wdata;
      if (offset == REG_PARAM) param_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      param_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      param_q <= param_d;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (offset)
      REG_CTRL:   rdata_c = ctrl_q;
      REG_PARAM:  rdata_c = param_q;
      REG_STATUS: rdata_c = status_in;
      REG_ID:     rdata_c = DEVICE_ID;
      default:    rdata_c = '0;
    endcase
  end

  assign ctrl_out  = ctrl_q;
  assign param_out = param_q;

endmodule

// File: rtl/bus_target.sv
// Four-register bus target: address decode, wait states, ready/strobe handshake
// with abort and timeout, registered response outputs.
module bus_target
  import bus_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH  = 8,
  parameter int unsigned             DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = ADDR_WIDTH'(8'h10),
  parameter int unsigned             WAIT_STATES = 1,
  parameter int unsigned             TIMEOUT     = 16,
  parameter logic [DATA_WIDTH-1:0]   DEVICE_ID   = DATA_WIDTH'(16'hC3D1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  address_valid,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
  input  logic                  data_strobe,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  target_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            error,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  output logic [DATA_WIDTH-1:0] param_out
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TMO_CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              error_q, error_d;

  logic [ADDR_WIDTH-1:0]   offset_full;
  logic [1:0]              offset;
  logic                    in_window;
  logic                    ro_c;
  logic                    we_c;
  logic [DATA_WIDTH-1:0]   reg_rdata_c;

  assign offset_full = addr_q - BASE_ADDR;
  assign offset      = offset_full[1:0];
  assign in_window   = (addr_q >= BASE_ADDR) && (offset_full < ADDR_WIDTH'(4));
  assign ro_c        = write_q && !is_rw_reg(offset);

  // ready is presented one cycle after entering READY; strobes count only once it is visible
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = '0;
    error_d    = ERR_OK;
    ready_d    = 1'b0;
    rdata_d    = '0;
    we_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (address_valid) begin
          addr_d  = address;
          write_d = write;
          state_d = DECODE;
        end
      end
      DECODE: begin
        wait_cnt_d = '0;
        if (!in_window) begin
          state_d = IDLE;
        end else if (!address_valid) begin
          state_d = IDLE;
          error_d = ERR_ABORT;
        end else if (WAIT_STATES == 0) begin
          state_d = READY;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!address_valid) begin
          state_d = IDLE;
          error_d = ERR_ABORT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = READY;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      READY: begin
        tmo_cnt_d = tmo_cnt_q;
        if (!address_valid) begin
          state_d = IDLE;
          error_d = ERR_ABORT;
        end else if (ready_q && data_strobe) begin
          state_d = DONE;
          we_c    = write_q && !ro_c;
        end else if (ready_q) begin
          if (tmo_cnt_q == TMO_LAST) begin
            state_d = DONE;
            error_d = ERR_TIMEOUT;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (!address_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == READY && state_d == READY) begin
      ready_d = 1'b1;
      error_d = ro_c ? ERR_RO : ERR_OK;
      rdata_d = write_q ? '0 : reg_rdata_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      error_q    <= ERR_OK;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  bus_target_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEVICE_ID  (DEVICE_ID)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (reset),
    .we_c      (we_c),
    .offset    (offset),
    .wdata     (wdata),
    .status_in (status_in),
    .rdata_c   (reg_rdata_c),
    .ctrl_out  (ctrl_out),
    .param_out (param_out)
  );

  assign target_ready = ready_q;
  assign rdata        = rdata_q;
  assign error        = error_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed self-checking bench for bus_target (default parameters).
module tb_bus_target;

  logic        clk = 1'b0;
  logic        reset;
  logic        address_valid;
  logic [7:0]  address;
  logic        write;
  logic        data_strobe;
  logic [15:0] wdata;
  logic        target_ready;
  logic [15:0] rdata;
  logic [1:0]  error;
  logic [15:0] status_in;
  logic [15:0] ctrl_out;
  logic [15:0] param_out;

  int n_checks = 0;
  int n_pass   = 0;

  bus_target dut (
    .clk           (clk),
    .reset         (reset),
    .address_valid (address_valid),
    .address       (address),
    .write         (write),
    .data_strobe   (data_strobe),
    .wdata         (wdata),
    .target_ready  (target_ready),
    .rdata         (rdata),
    .error         (error),
    .status_in     (status_in),
    .ctrl_out      (ctrl_out),
    .param_out     (param_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // raise address_valid and return the number of edges until target_ready is seen
  task automatic start(input logic [7:0] a, input logic w, output int n);
    address = a;
    write = w;
    address_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (target_ready) break;
    end
  endtask

  task automatic strobe_and_release(input logic [15:0] wd);
    wdata = wd;
    data_strobe = 1'b1;
    step();
    data_strobe = 1'b0;
    check("ready_after_strobe", 32'(target_ready), 32'd0);
    check("error_after_strobe", 32'(error), 32'd0);
    address_valid = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int cnt;
    int bad;

    reset = 1'b0;
    address_valid = 1'b0;
    address = '0;
    write = 1'b0;
    data_strobe = 1'b0;
    wdata = '0;
    status_in = 16'h7777;
    step();
    step();
    check("rst_ready", 32'(target_ready), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ctrl", 32'(ctrl_out), 32'd0);
    check("rst_param", 32'(param_out), 32'd0);
    reset = 1'b1;
    step();

    // write CTRL, latency N+3 with one wait state
    start(8'h10, 1'b1, n);
    check("wr_ctrl_latency", 32'(n), 32'd4);
    check("wr_ctrl_error", 32'(error), 32'd0);
    check("wr_ctrl_rdata", 32'(rdata), 32'd0);
    check("ctrl_before_strobe", 32'(ctrl_out), 32'd0);
    strobe_and_release(16'hA5A5);
    check("ctrl_written", 32'(ctrl_out), 32'hA5A5);

    start(8'h11, 1'b1, n);
    check("wr_param_latency", 32'(n), 32'd4);
    strobe_and_release(16'hBEEF);
    check("param_written", 32'(param_out), 32'hBEEF);
    check("ctrl_kept", 32'(ctrl_out), 32'hA5A5);

    // read all four registers
    start(8'h10, 1'b0, n);
    check("rd_ctrl", 32'(rdata), 32'hA5A5);
    strobe_and_release(16'h0000);
    check("rd_rdata_cleared", 32'(rdata), 32'd0);
    start(8'h11, 1'b0, n);
    check("rd_param", 32'(rdata), 32'hBEEF);
    strobe_and_release(16'h0000);
    start(8'h12, 1'b0, n);
    check("rd_status", 32'(rdata), 32'h7777);
    strobe_and_release(16'h0000);
    start(8'h13, 1'b0, n);
    check("rd_id", 32'(rdata), 32'hC3D1);
    check("rd_id_error", 32'(error), 32'd0);
    strobe_and_release(16'h0000);

    // write to read-only STATUS
    start(8'h12, 1'b1, n);
    check("ro_latency", 32'(n), 32'd4);
    check("ro_error", 32'(error), 32'd1);
    strobe_and_release(16'h1234);
    check("ro_ctrl_kept", 32'(ctrl_out), 32'hA5A5);
    check("ro_param_kept", 32'(param_out), 32'hBEEF);

    // out-of-window address stays silent
    address = 8'h20;
    write = 1'b0;
    address_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (target_ready || rdata != 16'd0 || error != 2'd0) bad++;
    end
    check("oow_silent", 32'(bad), 32'd0);
    address_valid = 1'b0;
    step();

    // timeout after 16 ready cycles
    start(8'h10, 1'b0, n);
    check("tmo_latency", 32'(n), 32'd4);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (target_ready) cnt++;
      else break;
    end
    check("tmo_ready_cycles", 32'(cnt), 32'd16);
    check("tmo_error", 32'(error), 32'd3);
    step();
    check("tmo_error_pulse", 32'(error), 32'd0);
    check("tmo_done_ready", 32'(target_ready), 32'd0);
    address_valid = 1'b0;
    step();
    start(8'h11, 1'b0, n);
    check("tmo_back_to_idle", 32'(n), 32'd4);
    strobe_and_release(16'h0000);

    // abort in WAIT, strobe before READY is ignored
    address = 8'h10;
    write = 1'b1;
    wdata = 16'hFFFF;
    data_strobe = 1'b1;
    address_valid = 1'b1;
    step();
    step();
    address_valid = 1'b0;
    data_strobe = 1'b0;
    step();
    check("abort_wait_error", 32'(error), 32'd2);
    check("abort_wait_ready", 32'(target_ready), 32'd0);
    step();
    check("abort_wait_pulse", 32'(error), 32'd0);
    check("abort_wait_ctrl", 32'(ctrl_out), 32'hA5A5);

    // strobe together with address_valid falling is an abort
    start(8'h10, 1'b1, n);
    wdata = 16'hFFFF;
    data_strobe = 1'b1;
    address_valid = 1'b0;
    step();
    data_strobe = 1'b0;
    check("abort_rdy_error", 32'(error), 32'd2);
    check("abort_rdy_ready", 32'(target_ready), 32'd0);
    check("abort_rdy_ctrl", 32'(ctrl_out), 32'hA5A5);
    step();
    check("abort_rdy_pulse", 32'(error), 32'd0);

    // held address_valid does not restart
    start(8'h10, 1'b1, n);
    wdata = 16'h1111;
    data_strobe = 1'b1;
    step();
    data_strobe = 1'b0;
    check("held_ctrl", 32'(ctrl_out), 32'h1111);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (target_ready) cnt++;
    end
    check("held_no_ready", 32'(cnt), 32'd0);
    address_valid = 1'b0;
    step();
    start(8'h10, 1'b0, n);
    check("held_restart_latency", 32'(n), 32'd4);
    check("held_restart_rdata", 32'(rdata), 32'h1111);
    strobe_and_release(16'h0000);

    // reset in the middle of READY
    start(8'h10, 1'b0, n);
    check("pre_reset_rdata", 32'(rdata), 32'h1111);
    wdata = 16'h2222;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(target_ready), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_ctrl", 32'(ctrl_out), 32'd0);
    check("mid_rst_param", 32'(param_out), 32'd0);
    address_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    check("post_rst_ready", 32'(target_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
